// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the RAM-mailbox <-> 8N1 serial bridge.
package uart_bridge_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  // Status word field positions (mailbox word 2).
  localparam int RXD_LSB = 0;
  localparam int RX_TGL  = 8;
  localparam int TX_ACK  = 9;
  localparam int TX_BUSY = 10;
  localparam int RX_FERR = 11;

  // Command word request toggle (mailbox word 3).
  localparam int TX_REQ_BIT = 8;

  localparam logic [31:0] CMD_ADDR    = 32'h1001_000C;
  localparam logic [31:0] STATUS_ADDR = 32'h1001_0008;

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 receiver: two-flop synchroniser, falling-edge start detect, mid-bit sampling.
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  import uart_bridge_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = R_START;
      end
      R_START: if (cnt_q == HALF_END) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = sync2_q ? R_IDLE : R_DATA;  // high again at mid-start: glitch
      end
      R_DATA: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        shift_d = {sync2_q, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = R_STOP;
      end
      R_STOP: if (cnt_q == BIT_END) begin
        cnt_d        = '0;
        state_d      = R_IDLE;
        byte_valid_o = sync2_q;
        frame_err_o  = !sync2_q;
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/uart_mailbox_bridge.sv
// Mailbox bridge: TX command toggle handshake from word 3, registered status
// word plus one-cycle write strobe to word 2, and the 8N1 transmitter.
module uart_mailbox_bridge #(
  parameter int BIT_WIDTH    = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] READ_UART,
  output logic [BIT_WIDTH-1:0] WRITE_UART,
  output logic                 W_UART,
  input  logic                 uart_rx,
  output logic                 uart_tx
);
  import uart_bridge_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 tx_ack_d, tx_busy_d;
  logic [BIT_WIDTH-1:0] status_q, status_d;
  logic                 w_uart_q;
  logic                 rx_valid, rx_ferr;
  logic [7:0]           rx_byte;
  logic                 unused_cmd_bits;

  assign unused_cmd_bits = ^READ_UART[BIT_WIDTH-1:TX_REQ_BIT+1];

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (uart_rx),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      uart_tx_q  <= 1'b1;
      status_q   <= '0;
      w_uart_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      uart_tx_q  <= uart_tx_d;
      status_q   <= status_d;
      w_uart_q   <= (status_d != status_q);
    end
  end

  // TX FSM; READ_UART carries word 2 during strobe cycles, so it is ignored then.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_ack_d   = status_q[TX_ACK];
    tx_busy_d  = status_q[TX_BUSY];
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (!w_uart_q && (READ_UART[TX_REQ_BIT] != status_q[TX_ACK])) begin
          tx_byte_d  = READ_UART[7:0];
          tx_busy_d  = 1'b1;
          tx_state_d = START;
        end
      end
      START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = DATA;
      end
      DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == 3'd7) tx_state_d = STOP;
      end
      STOP: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_ack_d   = !status_q[TX_ACK];
        tx_busy_d  = 1'b0;
        tx_state_d = IDLE;
      end
      default: tx_state_d = IDLE;
    endcase

    // Line level follows the state being entered so uart_tx stays registered.
    case (tx_state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = tx_byte_d[tx_idx_d];
      default: uart_tx_d = 1'b1;
    endcase
  end

  always_comb begin
    status_d                = '0;
    status_d[RXD_LSB +: 8]  = rx_valid ? rx_byte : status_q[RXD_LSB +: 8];
    status_d[RX_TGL]        = status_q[RX_TGL] ^ rx_valid;
    status_d[TX_ACK]        = tx_ack_d;
    status_d[TX_BUSY]       = tx_busy_d;
    status_d[RX_FERR]       = rx_valid ? 1'b0 : (rx_ferr | status_q[RX_FERR]);
  end

  assign WRITE_UART = status_q;
  assign W_UART     = w_uart_q;
  assign uart_tx    = uart_tx_q;

endmodule

// File: tb/tb_uart_mailbox_bridge.sv
// Randomised bench for uart_mailbox_bridge against a field-level status model.
module tb_uart_mailbox_bridge;
  localparam int CPB = 8;
  localparam int BW  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          uart_tx, w_uart;
  logic [BW-1:0] read_uart, write_uart;
  logic [BW-1:0] ram_w2 = '0;
  logic [BW-1:0] ram_w3 = '0;
  logic [BW-1:0] last_status = '0;
  int            checks = 0;
  int            failures = 0;
  int            strobe_cnt = 0;

  // Reference model: the status fields as the CPU should see them.
  logic [7:0] m_rxd = '0;
  logic       m_rxtgl = 1'b0, m_ack = 1'b0, m_busy = 1'b0, m_ferr = 1'b0;

  uart_mailbox_bridge #(.BIT_WIDTH(BW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .READ_UART  (read_uart),
    .WRITE_UART (write_uart),
    .W_UART     (w_uart),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  // RAM port: shows word 2 during a strobe, word 3 otherwise; commits word 2 next edge.
  assign read_uart = w_uart ? ram_w2 : ram_w3;
  always @(posedge clk) if (w_uart === 1'b1) ram_w2 <= write_uart;
  always @(negedge clk) if (w_uart === 1'b1) begin
    strobe_cnt++;
    last_status = write_uart;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [BW-1:0] model_status();
    logic [BW-1:0] s;
    s = '0;
    s[7:0] = m_rxd;
    s[8]   = m_rxtgl;
    s[9]   = m_ack;
    s[10]  = m_busy;
    s[11]  = m_ferr;
    return s;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expects the command already presented and accepted on the next edge.
  task automatic check_frame(input logic [7:0] b);
    logic exp_bit;
    step();
    m_busy = 1'b1;
    checks++;
    if (w_uart !== 1'b1 || write_uart !== model_status()) begin
      failures++;
      $display("FAIL tx_accept: W_UART=%0b WRITE_UART=%h, expected 1 / %h", w_uart, write_uart, model_status());
    end
    for (int slot = 0; slot < 10; slot++) begin
      exp_bit = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot-1];
      for (int c = 0; c < CPB; c++) begin
        checks++;
        if (uart_tx !== exp_bit) begin
          failures++;
          $display("FAIL tx_line slot%0d cyc%0d: uart_tx=%0b, expected %0b", slot, c, uart_tx, exp_bit);
        end
        step();
      end
    end
    m_ack  = ~m_ack;
    m_busy = 1'b0;
    checks++;
    if (w_uart !== 1'b1 || write_uart !== model_status()) begin
      failures++;
      $display("FAIL tx_done: W_UART=%0b WRITE_UART=%h, expected 1 / %h", w_uart, write_uart, model_status());
    end
  endtask

  task automatic send_tx(input logic [7:0] b, input logic [22:0] junk);
    int s0;
    s0 = strobe_cnt;
    ram_w3 = {junk, ~m_ack, b};
    check_frame(b);
    for (int c = 0; c < 3 * CPB; c++) begin
      step();
      checks++;
      if (uart_tx !== 1'b1) begin
        failures++;
        $display("FAIL tx_no_repeat: uart_tx=%0b, expected 1", uart_tx);
      end
    end
    checks++;
    if (strobe_cnt - s0 !== 2) begin
      failures++;
      $display("FAIL tx_strobes: got %0d, expected 2", strobe_cnt - s0);
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      step(CPB);
    end
    uart_rx = stop_bit;
    step(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic rx_frame_check(input logic [7:0] b, input logic stop_bit);
    int s0;
    s0 = strobe_cnt;
    drive_rx(b, stop_bit);
    step(CPB);
    if (stop_bit) begin
      m_rxd   = b;
      m_rxtgl = ~m_rxtgl;
      m_ferr  = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
    checks++;
    if (strobe_cnt - s0 !== 1 || last_status !== model_status()) begin
      failures++;
      $display("FAIL rx_frame %h stop=%0b: strobes=%0d status=%h, expected 1 / %h",
               b, stop_bit, strobe_cnt - s0, last_status, model_status());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    uart_rx = 1'b1;
    ram_w3 = '0;
    step(3);
    checks++;
    if (uart_tx !== 1'b1 || w_uart !== 1'b0 || write_uart !== '0) begin
      failures++;
      $display("FAIL reset_values: uart_tx=%0b W_UART=%0b WRITE_UART=%h, expected 1/0/0", uart_tx, w_uart, write_uart);
    end
    rst_n = 1'b1;
    step(50);
    checks++;
    if (strobe_cnt !== 0) begin
      failures++;
      $display("FAIL reset_quiet: strobes=%0d, expected 0", strobe_cnt);
    end
  endtask

  task automatic test_tx();
    send_tx(8'h55, '0);
  endtask

  task automatic test_rx();
    rx_frame_check(8'hA3, 1'b1);
    rx_frame_check(8'h3C, 1'b1);
  endtask

  task automatic test_rx_faults();
    rx_frame_check(8'h5A, 1'b0);
    rx_frame_check(8'hC7, 1'b1);
  endtask

  task automatic test_glitch();
    int s0;
    s0 = strobe_cnt;
    uart_rx = 1'b0;
    step(2);
    uart_rx = 1'b1;
    step(3 * CPB);
    checks++;
    if (strobe_cnt - s0 !== 0 || write_uart !== model_status()) begin
      failures++;
      $display("FAIL rx_glitch: strobes=%0d status=%h, expected 0 / %h", strobe_cnt - s0, write_uart, model_status());
    end
  endtask

  // TX stop-end lands 81 edges after the command; RX stop-end 79 after the start bit.
  task automatic test_concurrent();
    int s0;
    logic [7:0] btx, brx;
    btx = 8'($urandom);
    brx = 8'($urandom);
    s0 = strobe_cnt;
    ram_w3 = {23'd0, ~m_ack, btx};
    step(2);
    drive_rx(brx, 1'b1);
    step(CPB);
    m_ack   = ~m_ack;
    m_busy  = 1'b0;
    m_rxd   = brx;
    m_rxtgl = ~m_rxtgl;
    m_ferr  = 1'b0;
    checks++;
    if (strobe_cnt - s0 !== 2 || last_status !== model_status()) begin
      failures++;
      $display("FAIL concurrent: strobes=%0d status=%h, expected 2 / %h", strobe_cnt - s0, last_status, model_status());
    end
  endtask

  task automatic test_reset_mid_tx();
    int s0;
    logic [7:0] b;
    if (m_ack) send_tx(8'($urandom), 23'($urandom));
    b = 8'($urandom);
    ram_w3 = {23'd0, 1'b1, b};
    step(1 + 4 * CPB);
    s0 = strobe_cnt;
    rst_n = 1'b0;
    step();
    checks++;
    if (uart_tx !== 1'b1 || w_uart !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_tx: uart_tx=%0b W_UART=%0b, expected 1/0", uart_tx, w_uart);
    end
    step();
    m_rxd = '0; m_rxtgl = 1'b0; m_ack = 1'b0; m_busy = 1'b0; m_ferr = 1'b0;
    checks++;
    if (write_uart !== '0 || strobe_cnt - s0 !== 0) begin
      failures++;
      $display("FAIL reset_mid_tx_status: WRITE_UART=%h strobes=%0d, expected 0/0", write_uart, strobe_cnt - s0);
    end
    rst_n = 1'b1;
    check_frame(b);
    step(2);
    checks++;
    if (strobe_cnt - s0 !== 2) begin
      failures++;
      $display("FAIL reset_resend_strobes: got %0d, expected 2", strobe_cnt - s0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0)
        send_tx(8'($urandom), 23'($urandom));
      else
        rx_frame_check(8'($urandom), $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_rx_faults();
    test_glitch();
    test_concurrent();
    test_reset_mid_tx();
    test_random();
    test_concurrent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
